// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, divisor arithmetic, receiver FSM
// encoding and the majority-vote sample window.
package uart_pkg;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned DIV_W          = 9;
  localparam logic [3:0]  SAMPLE_FIRST   = 4'd6;
  localparam logic [3:0]  SAMPLE_LAST    = 4'd12;
  localparam logic [3:0]  SUB_LAST       = 4'd15;
  localparam logic [2:0]  VOTE_THRESHOLD = 3'd4;

  // Codes 5..7 are unused and fall back to the slowest rate.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (baud_sel_e'(sel))
      BAUD_19200:  return 19_200;
      BAUD_38400:  return 38_400;
      BAUD_57600:  return 57_600;
      BAUD_115200: return 115_200;
      default:     return 9_600;
    endcase
  endfunction

  // Terminal count of the 16x oversampling divider; a tick every DIV+1 cycles.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                input logic [2:0]  sel);
    int unsigned d;
    d = clk_hz / (OVERSAMPLE * baud_rate(sel)) - 1;
    return d[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial line, baud select and received-byte outputs of the UART receiver.
interface uart_byte_rx_if;
  logic       rs232_rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       rx_err;
  logic       uart_state;

  modport master (
    output rs232_rx, baud_set,
    input  data_byte, rx_done, rx_err, uart_state
  );

  modport slave (
    input  rs232_rx, baud_set,
    output data_byte, rx_done, rx_err, uart_state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator; the baud select is captured on clear so a
// frame keeps one rate even if the select input moves underneath it.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] baud_set,
  output logic       tick
);

  logic [2:0]       sel;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  // Each arm is a constant expression, so this folds to a small mux of constants.
  // NOTE: always_comb assigns div on every path (default arm) so no latch is inferred.
  always_comb begin
    div = baud_div(CLK_HZ, 3'd0);
    case (sel)
      3'd1:    div = baud_div(CLK_HZ, 3'd1);
      3'd2:    div = baud_div(CLK_HZ, 3'd2);
      3'd3:    div = baud_div(CLK_HZ, 3'd3);
      3'd4:    div = baud_div(CLK_HZ, 3'd4);
      default: div = baud_div(CLK_HZ, 3'd0);
    endcase
  end

  assign tick = !clr && (cnt == div);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
      cnt <= '0;
    end else if (clr) begin
      sel <= baud_set;
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes the line, oversamples 16x, majority-votes
// samples 6..12 of each bit and strobes rx_done / rx_err at the stop bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input logic           clk,
  input logic           rst_n,
  uart_byte_rx_if.slave bus
);

  logic       sync1, sync2, sync3;
  logic       fall;
  logic       start;
  logic       tick;
  rx_state_e  state;
  logic [3:0] sub_cnt;
  logic [3:0] bit_idx;
  logic [2:0] ones;
  logic [2:0] ones_nxt;
  logic       vote;
  logic [7:0] shift;
  logic [7:0] data_q;
  logic       done_q, err_q, busy_q;

  // sync3 is the edge-detect register; all three idle high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= bus.rs232_rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall  = sync3 && !sync2;
  assign start = (state == ST_IDLE) && fall;

  uart_baud_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .baud_set (bus.baud_set),
    .tick     (tick)
  );

  // Running ones-count including the current sample, so the vote at tick 12 sees all 7.
  always_comb begin
    ones_nxt = ones;
    if (sub_cnt >= SAMPLE_FIRST && sub_cnt <= SAMPLE_LAST)
      ones_nxt = ones + {2'b00, sync2};
    vote = (ones_nxt >= VOTE_THRESHOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sub_cnt <= '0;
      bit_idx <= '0;
      ones    <= '0;
      shift   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == ST_IDLE) begin
        if (fall) begin
          state   <= ST_START;
          busy_q  <= 1'b1;
          sub_cnt <= '0;
          bit_idx <= '0;
          ones    <= '0;
        end
      end else if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
        ones    <= (sub_cnt == SUB_LAST) ? 3'd0 : ones_nxt;
        if (sub_cnt == SAMPLE_LAST) begin
          unique case (state)
            ST_START: if (vote) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
            ST_DATA:  shift <= {vote, shift[7:1]};
            ST_STOP: begin
              // Leaving at tick 12 frees the rest of the stop bit for the next start edge.
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              if (vote) begin
                data_q <= shift;
                done_q <= 1'b1;
              end else begin
                err_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (sub_cnt == SUB_LAST) begin
          if (state == ST_START) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end else if (state == ST_DATA) begin
            if (bit_idx == 4'd7) begin
              state   <= ST_STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
      end
    end
  end

  assign bus.data_byte  = data_q;
  assign bus.rx_done    = done_q;
  assign bus.rx_err     = err_q;
  assign bus.uart_state = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed and randomized frames against a bit-level line model; outcomes are
// checked against the bytes the bench itself chose to send.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 3_686_400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Line observer.
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0;
  int         run_len = 0, last_run = 0, rise_cyc = 0, start_cyc = 0;
  logic       prev_state = 1'b0;
  logic [7:0] got_q[$];

  initial forever begin
    @(negedge clk);
    if (bus.rx_done) begin
      done_cnt++;
      got_q.push_back(bus.data_byte);
    end
    if (bus.rx_err) err_cnt++;
    if (bus.rx_done && bus.rx_err) both_cnt++;
    if (bus.uart_state && !prev_state) begin
      rise_cnt++;
      rise_cyc = cyc;
      run_len  = 0;
    end
    if (bus.uart_state) run_len++;
    else if (prev_state) last_run = run_len;
    prev_state = bus.uart_state;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int baud_of(input int sel);
    case (sel)
      1:       return 19_200;
      2:       return 38_400;
      3:       return 57_600;
      4:       return 115_200;
      default: return 9_600;
    endcase
  endfunction

  // Cycles per bit: 16 sub-samples, each CLK_HZ/(16*baud) clocks long.
  function automatic int bit_cycles(input int sel);
    return 16 * (int'(CLK_HZ) / (16 * baud_of(sel)));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame a clock at a time. Sub-sample k of slot s is centred
  // (16*s + k + 1) sub-periods after the start edge; dips pull the line low
  // briefly around the selected sub-samples of dip_slot.
  task automatic send_frame(input logic [7:0] b, input int sel, input logic stop_val,
                            input int dip_slot, input logic [15:0] dip_subs,
                            input int max_cycles, input int new_sel);
    int         bc;
    int         sc;
    logic [9:0] frame;
    bc    = bit_cycles(sel);
    sc    = bc / 16;
    frame = {stop_val, b, 1'b0};
    bus.baud_set = 3'(sel);
    for (int t = 0; t < 10 * bc && t < max_cycles; t++) begin
      int   slot;
      logic v;
      slot = t / bc;
      v    = frame[slot];
      if (slot == dip_slot)
        for (int k = 6; k <= 12; k++) begin
          int c;
          c = (16 * slot + k + 1) * sc;
          if (dip_subs[k] && t >= c - sc / 4 && t <= c + sc / 4) v = 1'b0;
        end
      if (t == 0) start_cyc = cyc;
      if (t == bc) bus.baud_set = 3'(new_sel);
      bus.rs232_rx = v;
      @(negedge clk);
    end
    bus.rs232_rx = 1'b1;
  endtask

  initial begin
    int d0, e0, r0, bc0, sc0;
    logic [7:0] rb;
    int rs, ns;

    bus.rs232_rx = 1'b1;
    bus.baud_set = 3'd0;
    bc0 = bit_cycles(0);
    sc0 = bc0 / 16;
    idle(4);
    chk("reset_data_byte", bus.data_byte, 8'h00);
    chk("reset_rx_done", bus.rx_done, 1'b0);
    chk("reset_rx_err", bus.rx_err, 1'b0);
    chk("reset_uart_state", bus.uart_state, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Divisor arithmetic at the production clock, including the 5..7 fallback.
    for (int s = 0; s < 8; s++)
      chk($sformatf("div_50mhz_sel%0d", s), 32'(baud_div(50_000_000, 3'(s))),
          32'(50_000_000 / (16 * baud_of(s)) - 1));

    // 0x5A at 9600 with ideal timing.
    send_frame(8'h5A, 0, 1'b1, -1, '0, 1 << 30, 0);
    idle(2 * bc0);
    chk("5a_done_count", done_cnt, 1);
    chk("5a_byte", got_q[$], 8'h5A);
    chk("5a_data_byte_held", bus.data_byte, 8'h5A);
    chk("5a_no_err", err_cnt, 0);
    chk("5a_edge_to_state", rise_cyc - start_cyc, 3);
    chk("5a_state_len", (last_run >= 157 * sc0 - 2 && last_run <= 157 * sc0 + 2), 1'b1);

    // 0x00 then 0xFF back-to-back at 115200, one stop bit.
    d0 = done_cnt; r0 = rise_cnt;
    send_frame(8'h00, 4, 1'b1, -1, '0, 1 << 30, 4);
    send_frame(8'hFF, 4, 1'b1, -1, '0, 1 << 30, 4);
    idle(2 * bit_cycles(4));
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_first", got_q[$-1], 8'h00);
    chk("b2b_second", got_q[$], 8'hFF);
    chk("b2b_starts", rise_cnt - r0, 2);
    chk("b2b_no_err", err_cnt, 0);

    // Short low glitch on an idle line at 9600: false start.
    d0 = done_cnt; r0 = rise_cnt;
    bus.baud_set = 3'd0;
    bus.rs232_rx = 1'b0;
    idle(8);
    bus.rs232_rx = 1'b1;
    idle(2 * bc0);
    chk("glitch_state_pulsed", rise_cnt - r0, 1);
    chk("glitch_state_len", (last_run >= 12 * sc0 && last_run <= 14 * sc0), 1'b1);
    chk("glitch_state_low", bus.uart_state, 1'b0);
    chk("glitch_no_done", done_cnt - d0, 0);
    chk("glitch_no_err", err_cnt, 0);
    chk("glitch_data_kept", bus.data_byte, 8'hFF);

    // 0xA5 with the stop bit held low: framing error.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, 0, 1'b0, -1, '0, 1 << 30, 0);
    idle(2 * bc0);
    chk("ferr_err_pulse", err_cnt - e0, 1);
    chk("ferr_no_done", done_cnt - d0, 0);
    chk("ferr_data_kept", bus.data_byte, 8'hFF);
    chk("ferr_never_both", both_cnt, 0);

    // Majority vote: 3 of 7 samples of data bit 3 flipped, then 4 of 7.
    send_frame(8'h0F, 0, 1'b1, 4, 16'b0000_0101_0100_0000, 1 << 30, 0);
    idle(2 * bc0);
    chk("vote3_byte", got_q[$], 8'h0F);
    send_frame(8'h0F, 0, 1'b1, 4, 16'b0001_0101_0100_0000, 1 << 30, 0);
    idle(2 * bc0);
    chk("vote4_byte", got_q[$], 8'h07);

    // Reset in the middle of the data bits of 0x33, then a clean 0xC3.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h33, 0, 1'b1, -1, '0, 5 * bc0, 0);
    chk("midframe_busy", bus.uart_state, 1'b1);
    rst_n = 1'b0;
    idle(2);
    chk("rst_data_byte", bus.data_byte, 8'h00);
    chk("rst_rx_done", bus.rx_done, 1'b0);
    chk("rst_rx_err", bus.rx_err, 1'b0);
    chk("rst_uart_state", bus.uart_state, 1'b0);
    rst_n = 1'b1;
    idle(2 * bc0);
    chk("aborted_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    chk("aborted_data_zero", bus.data_byte, 8'h00);
    send_frame(8'hC3, 0, 1'b1, -1, '0, 1 << 30, 0);
    idle(2 * bc0);
    chk("after_rst_byte", got_q[$], 8'hC3);
    chk("after_rst_count", done_cnt - d0, 1);

    // Random bytes and rates; baud_set is scrambled after the start bit.
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      rs = int'($urandom_range(0, 7));
      ns = int'($urandom_range(0, 7));
      d0 = done_cnt; e0 = err_cnt;
      send_frame(rb, rs, 1'b1, -1, '0, 1 << 30, ns);
      idle(2 * bit_cycles(rs));
      chk($sformatf("rand%0d_count", i), done_cnt - d0, 1);
      chk($sformatf("rand%0d_byte", i), got_q[$], rb);
      chk($sformatf("rand%0d_no_err", i), err_cnt - e0, 0);
    end

    chk("never_done_and_err", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
